// File: rtl/mat_operand_loader.sv
// Assembles a stream of signed elements into two N x N operand matrices
// and issues them to the matrix multiplier as one pair.
module mat_operand_loader #(
   parameter int W_IN = 8,
   parameter int N    = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic signed [W_IN-1:0]        s_data,
   input  logic                          s_last,
   output logic                          m_valid,
   output logic [N-1:0][N-1:0][W_IN-1:0] matrix_1,
   output logic [N-1:0][N-1:0][W_IN-1:0] matrix_2,
   output logic                          err,
   output logic [15:0]                   pair_count
);
   localparam int NN = N * N;
   localparam int P  = 2 * NN;
   localparam int LN = $clog2(N);
   localparam int CW = $clog2(P);

   typedef enum logic [1:0] {LOAD_A, LOAD_B, ISSUE, DISCARD} state_t;

   state_t                          state;
   logic [CW-1:0]                   cnt;
   logic [N-1:0][N-1:0][W_IN-1:0]   load_a;
   logic [N-1:0][N-1:0][W_IN-1:0]   load_b;
   logic [N-1:0][N-1:0][W_IN-1:0]   a_nxt;
   logic [N-1:0][N-1:0][W_IN-1:0]   b_nxt;
   logic                            beat;
   logic                            loading;
   logic                            at_end;
   logic                            early;
   logic                            missing;
   logic                            good;
   logic [LN-1:0]                   row;
   logic [LN-1:0]                   col;

   assign s_ready = !reset && (state != ISSUE);
   assign beat    = s_valid && s_ready;
   assign loading = (state == LOAD_A) || (state == LOAD_B);
   assign at_end  = (cnt == CW'(P - 1));
   assign early   = s_last && !at_end;
   assign missing = !s_last && at_end;
   assign good    = beat && loading && !early && !missing;
   // The counter MSB selects A or B; the low bits are row/column directly.
   assign row     = cnt[2*LN-1:LN];
   assign col     = cnt[LN-1:0];

   always_comb begin
      a_nxt = load_a;
      b_nxt = load_b;
      if (good) begin
         if (cnt[CW-1])
            b_nxt[row][col] = s_data;
         else
            a_nxt[row][col] = s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= LOAD_A;
         cnt        <= '0;
         m_valid    <= 1'b0;
         err        <= 1'b0;
         pair_count <= '0;
         matrix_1   <= '0;
         matrix_2   <= '0;
         load_a     <= '0;
         load_b     <= '0;
      end else begin
         m_valid <= 1'b0;
         err     <= 1'b0;
         load_a  <= a_nxt;
         load_b  <= b_nxt;
         unique case (state)
            LOAD_A, LOAD_B: begin
               if (beat) begin
                  if (early || missing) begin
                     err   <= 1'b1;
                     cnt   <= '0;
                     state <= missing ? DISCARD : LOAD_A;
                  end else if (at_end) begin
                     // Final beat is folded in via a_nxt/b_nxt so it
                     // lands in the outputs on this same edge.
                     state    <= ISSUE;
                     cnt      <= '0;
                     m_valid  <= 1'b1;
                     matrix_1 <= a_nxt;
                     matrix_2 <= b_nxt;
                     if (pair_count != 16'hFFFF)
                        pair_count <= pair_count + 16'd1;
                  end else begin
                     cnt <= cnt + CW'(1);
                     if (cnt == CW'(NN - 1))
                        state <= LOAD_B;
                  end
               end
            end
            ISSUE: begin
               state <= LOAD_A;
            end
            DISCARD: begin
               if (beat && s_last)
                  state <= LOAD_A;
            end
            default: begin
               state <= LOAD_A;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mat_operand_loader.sv
// Directed bench for mat_operand_loader (N=2, W_IN=8): cycle vector table
// plus hand-written framing-error, gap and reset sequences.
module tb_mat_operand_loader;
   logic                 clk = 1'b0;
   logic                 reset;
   logic                 s_valid;
   logic                 s_ready;
   logic signed [7:0]    s_data;
   logic                 s_last;
   logic                 m_valid;
   logic [1:0][1:0][7:0] matrix_1;
   logic [1:0][1:0][7:0] matrix_2;
   logic                 err;
   logic [15:0]          pair_count;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic        vld;
      logic [7:0]  dat;
      logic        lst;
      logic        rdy;
      logic        mv;
      logic        er;
      logic [15:0] pc;
      logic [31:0] m1;
      logic [31:0] m2;
   } vec_t;

   vec_t vec [19];

   mat_operand_loader #(.W_IN(8), .N(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .m_valid    (m_valid),
      .matrix_1   (matrix_1),
      .matrix_2   (matrix_2),
      .err        (err),
      .pair_count (pair_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs after the edge; return at the negedge.
   task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                      input logic r);
      @(posedge clk);
      #1;
      s_valid = v;
      s_data  = d;
      s_last  = l;
      reset   = r;
      @(negedge clk);
   endtask

   task automatic send_pair(input logic [63:0] b, input logic with_last,
                            input logic gaps);
      for (int k = 0; k < 8; k++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            for (int j = 0; j < g; j++) begin
               cyc(1'b0, 8'h00, 1'b0, 1'b0);
               chk("gap_mv", {31'd0, m_valid}, 32'd0);
            end
         end
         cyc(1'b1, b[8*k +: 8], with_last && (k == 7), 1'b0);
         chk("beat_rdy", {31'd0, s_ready}, 32'd1);
      end
   endtask

   task automatic issue_check(input logic [31:0] m1, input logic [31:0] m2,
                              input logic [15:0] pc);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("iss_mv", {31'd0, m_valid}, 32'd1);
      chk("iss_rdy", {31'd0, s_ready}, 32'd0);
      chk("iss_err", {31'd0, err}, 32'd0);
      chk("iss_m1", matrix_1, m1);
      chk("iss_m2", matrix_2, m2);
      chk("iss_pc", {16'd0, pair_count}, {16'd0, pc});
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("post_mv", {31'd0, m_valid}, 32'd0);
      chk("post_rdy", {31'd0, s_ready}, 32'd1);
      chk("post_m1", matrix_1, m1);
   endtask

   initial begin
      // Pair 1 = 1..8 then pair 2 = 9..16 with s_valid held through ISSUE.
      for (int i = 0; i < 19; i++) begin
         vec[i].vld = (i <= 16);
         vec[i].dat = (i < 8) ? 8'(i + 1) : (i == 8) ? 8'd9 :
                      (i <= 16) ? 8'(i) : 8'd0;
         vec[i].lst = (i == 7) || (i == 16);
         vec[i].rdy = !((i == 8) || (i == 17));
         vec[i].mv  = (i == 8) || (i == 17);
         vec[i].er  = 1'b0;
         vec[i].pc  = (i < 8) ? 16'd0 : (i < 17) ? 16'd1 : 16'd2;
         vec[i].m1  = (i < 8) ? 32'h0 : (i < 17) ? 32'h04030201 : 32'h0C0B0A09;
         vec[i].m2  = (i < 8) ? 32'h0 : (i < 17) ? 32'h08070605 : 32'h100F0E0D;
      end

      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      reset   = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("rst_rdy", {31'd0, s_ready}, 32'd0);
      chk("rst_mv", {31'd0, m_valid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_pc", {16'd0, pair_count}, 32'd0);
      chk("rst_m1", matrix_1, 32'd0);
      chk("rst_m2", matrix_2, 32'd0);

      for (int i = 0; i < 19; i++) begin
         cyc(vec[i].vld, vec[i].dat, vec[i].lst, 1'b0);
         chk($sformatf("v%0d_rdy", i), {31'd0, s_ready}, {31'd0, vec[i].rdy});
         chk($sformatf("v%0d_mv", i), {31'd0, m_valid}, {31'd0, vec[i].mv});
         chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vec[i].er});
         chk($sformatf("v%0d_pc", i), {16'd0, pair_count}, {16'd0, vec[i].pc});
         chk($sformatf("v%0d_m1", i), matrix_1, vec[i].m1);
         chk($sformatf("v%0d_m2", i), matrix_2, vec[i].m2);
      end

      // Negative values with random gaps; issue must follow last beat.
      send_pair(64'h409C05FE_00FF7F80, 1'b1, 1'b1);
      issue_check(32'h00FF7F80, 32'h409C05FE, 16'd3);

      // Early s_last on the third beat.
      cyc(1'b1, 8'h11, 1'b0, 1'b0);
      cyc(1'b1, 8'h12, 1'b0, 1'b0);
      cyc(1'b1, 8'h13, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("early_err", {31'd0, err}, 32'd1);
      chk("early_mv", {31'd0, m_valid}, 32'd0);
      chk("early_m1", matrix_1, 32'h00FF7F80);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("early_err_1cyc", {31'd0, err}, 32'd0);
      send_pair(64'h28272625_24232221, 1'b1, 1'b0);
      chk("early_hold_m1", matrix_1, 32'h00FF7F80);
      chk("early_hold_m2", matrix_2, 32'h409C05FE);
      issue_check(32'h24232221, 32'h28272625, 16'd4);

      // Missing s_last, then three junk beats ending with s_last.
      send_pair(64'h38373635_34333231, 1'b0, 1'b0);
      cyc(1'b1, 8'hA1, 1'b0, 1'b0);
      chk("miss_err", {31'd0, err}, 32'd1);
      chk("miss_mv", {31'd0, m_valid}, 32'd0);
      cyc(1'b1, 8'hA2, 1'b0, 1'b0);
      chk("junk2_err", {31'd0, err}, 32'd0);
      cyc(1'b1, 8'hA3, 1'b1, 1'b0);
      chk("junk3_err", {31'd0, err}, 32'd0);
      chk("junk3_rdy", {31'd0, s_ready}, 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("junk_end_err", {31'd0, err}, 32'd0);
      chk("junk_end_mv", {31'd0, m_valid}, 32'd0);
      chk("junk_end_pc", {16'd0, pair_count}, 32'd4);
      send_pair(64'h48474645_44434241, 1'b1, 1'b0);
      issue_check(32'h44434241, 32'h48474645, 16'd5);

      // Reset after five beats abandons the pair.
      for (int k = 0; k < 5; k++)
         cyc(1'b1, 8'(8'h51 + k), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("mrst_rdy", {31'd0, s_ready}, 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("mrst_rdy1", {31'd0, s_ready}, 32'd1);
      chk("mrst_mv", {31'd0, m_valid}, 32'd0);
      chk("mrst_err", {31'd0, err}, 32'd0);
      chk("mrst_pc", {16'd0, pair_count}, 32'd0);
      chk("mrst_m1", matrix_1, 32'd0);
      chk("mrst_m2", matrix_2, 32'd0);
      send_pair(64'h58575655_54535251, 1'b1, 1'b0);
      issue_check(32'h54535251, 32'h58575655, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
